// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: request tags travelling
// alongside RAM reads, and the grant sources in priority order.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU
  } tag_t;

  // Enumerated in descending priority; GRANT_NONE means the RAM idles.
  typedef enum logic [2:0] {
    GRANT_NONE,
    GRANT_CPU_STARVED,
    GRANT_VID_ACTIVE,
    GRANT_CPU,
    GRANT_VID
  } grant_e;

  localparam int unsigned RAM_LAT_MAX = 3;

endpackage

// File: rtl/vram_tag_pipe.sv
// Shift register of request tags, aligned with the RAM read pipeline so the
// returning data can be steered to the requester that issued the access.
module vram_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [Depth-1:0] stage_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between display fetch and CPU: one grant per clock,
// video first in active display, CPU first in blanking, with a CPU starvation guard.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW           = 13,
  parameter int unsigned DW           = 8,
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_blank,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] WaitMax = CW'(STARVE_LIMIT);

  grant_e        grant;
  logic [CW-1:0] wait_q, wait_d;
  tag_t          tag_in, tag_out;

  // Acks are suppressed while reset is held so every output reads 0.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset)                              grant = GRANT_NONE;
    else if (cpu_req && wait_q == WaitMax)   grant = GRANT_CPU_STARVED;
    else if (!vid_blank && vid_req)          grant = GRANT_VID_ACTIVE;
    else if (cpu_req)                        grant = GRANT_CPU;
    else if (vid_req)                        grant = GRANT_VID;
  end

  assign cpu_ack = (grant == GRANT_CPU_STARVED) || (grant == GRANT_CPU);
  assign vid_ack = (grant == GRANT_VID_ACTIVE) || (grant == GRANT_VID);

  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || cpu_ack) wait_d = '0;
    else if (wait_q != WaitMax) wait_d = wait_q + CW'(1);
  end

  always_comb begin
    tag_in = TAG_NONE;
    if (cpu_ack && !cpu_we) tag_in = TAG_CPU;
    else if (vid_ack)       tag_in = TAG_VID;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      wait_q <= wait_d;
      ram_en <= cpu_ack || vid_ack;
      ram_we <= cpu_ack && cpu_we;
      if (cpu_ack) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else if (vid_ack) begin
        ram_addr  <= vid_addr;
      end
    end
  end

  vram_tag_pipe #(
    .Depth(RAM_LAT + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Last tag stage lines up with ram_rdata; data is captured and held per requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      vid_rvalid <= (tag_out == TAG_VID);
      cpu_rvalid <= (tag_out == TAG_CPU);
      if (tag_out == TAG_VID) vid_rdata <= ram_rdata;
      if (tag_out == TAG_CPU) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomised checks of vram_arbiter against a bench-side RAM and
// reference memory; read data returns 2+RAM_LAT cycles after the ack cycle.
module tb_vram_arbiter;

  localparam int unsigned AW           = 13;
  localparam int unsigned DW           = 8;
  localparam int unsigned RAM_LAT      = 2;
  localparam int unsigned STARVE_LIMIT = 16;
  localparam int          Lat          = 2 + RAM_LAT;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_blank, vid_req, vid_ack, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] rd_pipe [RAM_LAT];
  bit            mem_init = 1'b0;

  vram_arbiter #(
    .AW(AW), .DW(DW), .RAM_LAT(RAM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .vid_blank(vid_blank), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data valid RAM_LAT cycles after the ram_en cycle.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init <= 1'b1;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  function automatic logic [42:0] all_outs();
    return {vid_ack, cpu_ack, vid_rvalid, vid_rdata, cpu_rvalid, cpu_rdata,
            ram_en, ram_we, ram_addr, ram_wdata};
  endfunction

  task automatic test_reset();
    reset = 1'b0; vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 13'h0003;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0004; cpu_wdata = 8'h77;
    #3;
    n_cmp++;
    if (all_outs() !== 43'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", all_outs());
    end
    repeat (2) @(posedge clk);
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (all_outs() !== 43'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h, expected 0", all_outs());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_write_read();
    int t_ack, hits, vhits, hit_cyc;
    logic [DW-1:0] rd;
    vid_blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0100; cpu_wdata = 8'hA5;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1 || vid_ack !== 1'b0) begin
      n_fail++; $display("FAIL cpu_write_ack: got cpu=%b vid=%b, expected 1/0", cpu_ack, vid_ack);
    end
    ref_mem[13'h0100] = 8'hA5;
    @(posedge clk); #1;
    n_cmp++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 13'h0100, 8'hA5}) begin
      n_fail++; $display("FAIL ram_write_port: got en=%b we=%b a=%h d=%h, expected 1 1 0100 a5",
                         ram_en, ram_we, ram_addr, ram_wdata);
    end
    cpu_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1) begin
      n_fail++; $display("FAIL cpu_read_ack: got %b, expected 1", cpu_ack);
    end
    t_ack = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n_cmp++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 13'h0100}) begin
      n_fail++; $display("FAIL ram_read_port: got en=%b we=%b a=%h, expected 1 0 0100",
                         ram_en, ram_we, ram_addr);
    end
    hits = 0; vhits = 0; hit_cyc = -1; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vid_rvalid) vhits++;
      if (cpu_rvalid) begin hits++; hit_cyc = cyc; rd = cpu_rdata; end
    end
    n_cmp++;
    if (hits != 1 || hit_cyc != t_ack + Lat || rd !== 8'hA5) begin
      n_fail++; $display("FAIL cpu_read_data: got %0d pulses at +%0d data %h, expected 1 at +%0d a5",
                         hits, hit_cyc - t_ack, rd, Lat);
    end
    n_cmp++;
    if (vhits != 0) begin
      n_fail++; $display("FAIL no_vid_rvalid: got %0d pulses, expected 0", vhits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic ev, ec;
    vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 13'h0020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0101;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ev = (i != 16); ec = (i == 16);
      n_cmp++;
      if (vid_ack !== ev || cpu_ack !== ec) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got vid=%b cpu=%b, expected vid=%b cpu=%b",
                           i, vid_ack, cpu_ack, ev, ec);
      end
      if (i == 17) begin
        n_cmp++;
        if (dut.wait_q !== '0) begin
          n_fail++; $display("FAIL starve_wait_clear: got %0d, expected 0", dut.wait_q);
        end
      end
      @(posedge clk); #1;
      vid_addr = vid_addr + 13'd1;
      if (i == 16) cpu_req = 1'b0;
    end
    vid_req = 1'b0;
    repeat (Lat + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_blank_priority();
    int t_ack, hits;
    logic [DW-1:0] rd;
    vid_blank = 1'b1; vid_req = 1'b1; vid_addr = 13'h0010;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1 || vid_ack !== 1'b0) begin
      n_fail++; $display("FAIL blank_cpu_first: got cpu=%b vid=%b, expected 1/0", cpu_ack, vid_ack);
    end
    ref_mem[13'h0200] = 8'h3C;
    @(posedge clk); #1;
    cpu_we = 1'b0; vid_blank = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vid_ack !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL active_video_first: got vid=%b cpu=%b, expected 1/0", vid_ack, cpu_ack);
    end
    @(posedge clk); #1;
    vid_blank = 1'b1; vid_addr = 13'h0011;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1 || vid_ack !== 1'b0) begin
      n_fail++; $display("FAIL blank_toggle_cpu: got cpu=%b vid=%b, expected 1/0", cpu_ack, vid_ack);
    end
    t_ack = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vid_ack !== 1'b1) begin
      n_fail++; $display("FAIL video_after_cpu: got %b, expected 1", vid_ack);
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    hits = 0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_rvalid) begin
        hits++; rd = cpu_rdata;
        if (cyc != t_ack + Lat) hits += 100;
      end
    end
    n_cmp++;
    if (hits != 1 || rd !== 8'h3C) begin
      n_fail++; $display("FAIL cpu_read_after_write: got code %0d data %h, expected 1 3c", hits, rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_video_burst();
    logic ev, ea;
    logic [DW-1:0] ed;
    vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 13'h0040;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = (i < 8);
      ev = (i >= Lat) && (i < Lat + 8);
      ed = ref_mem[13'h0040 + 13'(i - Lat)];
      n_cmp++;
      if (vid_ack !== ea || vid_rvalid !== ev || cpu_rvalid !== 1'b0 ||
          (ev && vid_rdata !== ed)) begin
        n_fail++;
        $display("FAIL burst[%0d]: got ack=%b rv=%b d=%h crv=%b, expected ack=%b rv=%b d=%h crv=0",
                 i, vid_ack, vid_rvalid, vid_rdata, cpu_rvalid, ea, ev, ed);
      end
      @(posedge clk); #1;
      if (i < 7) vid_addr = 13'h0041 + 13'(i);
      else vid_req = 1'b0;
    end
  endtask

  task automatic test_reset_inflight();
    int hits;
    vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 13'h0050;
    @(posedge clk); #1;
    vid_addr = 13'h0051;
    @(posedge clk); #1;
    vid_req = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== 43'd0) begin
      n_fail++; $display("FAIL reset_async_clear: got %h, expected 0", all_outs());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vid_rvalid || cpu_rvalid) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_fail++; $display("FAIL no_rvalid_after_reset: got %0d pulses, expected 0", hits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t vq[$], cq[$], e;
    int   cw;
    logic v_acked, c_acked, exp_v, exp_c;
    cw = 0; v_acked = 1'b0; c_acked = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0;
    for (int n = 0; n < 10000 + Lat + 2; n++) begin
      if (n < 10000) begin
        if (v_acked || !vid_req) begin
          vid_req  = ($urandom_range(0, 9) < 6);
          vid_addr = 13'($urandom_range(0, 63));
        end
        if (c_acked || !cpu_req) begin
          cpu_req   = ($urandom_range(0, 9) < 5);
          cpu_we    = $urandom_range(0, 1) == 1;
          cpu_addr  = 13'($urandom_range(0, 63));
          cpu_wdata = 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) vid_blank = ~vid_blank;
      end else begin
        vid_req = 1'b0; cpu_req = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if ((vid_ack && cpu_ack) || (vid_ack && !vid_req) || (cpu_ack && !cpu_req)) begin
        n_fail++; $display("FAIL rnd_ack_exclusive: got vid=%b cpu=%b req=%b%b, expected legal",
                           vid_ack, cpu_ack, vid_req, cpu_req);
      end
      exp_v = (vq.size() > 0) && (vq[0].due == cyc);
      n_cmp++;
      if (vid_rvalid !== exp_v || (exp_v && vid_rdata !== vq[0].data)) begin
        n_fail++; $display("FAIL rnd_vid_read @%0d: got rv=%b d=%h, expected rv=%b d=%h", cyc,
                           vid_rvalid, vid_rdata, exp_v, exp_v ? vq[0].data : 8'h00);
      end
      if (exp_v) void'(vq.pop_front());
      exp_c = (cq.size() > 0) && (cq[0].due == cyc);
      n_cmp++;
      if (cpu_rvalid !== exp_c || (exp_c && cpu_rdata !== cq[0].data)) begin
        n_fail++; $display("FAIL rnd_cpu_read @%0d: got rv=%b d=%h, expected rv=%b d=%h", cyc,
                           cpu_rvalid, cpu_rdata, exp_c, exp_c ? cq[0].data : 8'h00);
      end
      if (exp_c) void'(cq.pop_front());
      if (vid_ack) begin
        e.data = ref_mem[vid_addr]; e.due = cyc + Lat; vq.push_back(e);
      end
      if (cpu_ack) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else begin e.data = ref_mem[cpu_addr]; e.due = cyc + Lat; cq.push_back(e); end
      end
      // cw counts un-acked cycles before the ack cycle itself.
      if (cpu_req && !cpu_ack) cw++; else cw = 0;
      n_cmp++;
      if (cw > STARVE_LIMIT) begin
        n_fail++; $display("FAIL rnd_cpu_starve: got wait %0d, expected <= %0d", cw, STARVE_LIMIT);
      end
      v_acked = vid_ack; c_acked = cpu_ack;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (vq.size() != 0 || cq.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d/%0d pending, expected 0/0", vq.size(), cq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_blank_priority();
    test_video_burst();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
